// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared definitions for the SPI flash ROM model.
//   - FSM state encoding (3 bits)
//   - default READ / FAST_READ opcodes
//   - bit counter width
package spi_flash_pkg;

    localparam logic [7:0] READ_OP      = 8'h03;
    localparam logic [7:0] FAST_READ_OP = 8'h0B;

    // Wide enough to count the 32 bits of a 4-byte address.
    localparam int BIT_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: brings the asynchronous SPI pins into the clk domain.
//   clk, rst          system clock, synchronous active-high reset
//   cs_n, sclk, DI    raw SPI pins
//   cs_n_s            synchronised chip select (resets high = deselected)
//   di_s              synchronised MOSI, aligned with sclk_rise
//   sclk_rise/fall    one-clk pulses on synchronised sclk edges
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sclk,
    input  logic DI,
    output logic cs_n_s,
    output logic di_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [1:0] cs_ff;
    logic [1:0] sclk_ff;
    logic [1:0] di_ff;
    logic       sclk_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_ff   <= 2'b11;
            sclk_ff <= 2'b00;
            di_ff   <= 2'b00;
            sclk_d  <= 1'b0;
        end else begin
            cs_ff   <= {cs_ff[0], cs_n};
            sclk_ff <= {sclk_ff[0], sclk};
            di_ff   <= {di_ff[0], DI};
            sclk_d  <= sclk_ff[1];
        end
    end

    assign cs_n_s    = cs_ff[1];
    // DI and sclk share the same synchroniser depth, so di_s is the value
    // the master launched before the edge that produced sclk_rise.
    assign di_s      = di_ff[1];
    assign sclk_rise = sclk_ff[1] & ~sclk_d;
    assign sclk_fall = ~sclk_ff[1] & sclk_d;

endmodule

// File: rtl/spi_flash_rom_sync.sv
// spi_flash_rom_sync: read-only SPI (mode 0) flash slave, oversampled on clk.
// Supports READ and FAST_READ (with dummy cycles), wrap-around sequential
// reads and a one-clk cmd_err pulse for unknown opcodes.
//   clk, rst    system clock, synchronous active-high reset
//   cs_n, sclk  SPI chip select / clock (asynchronous to clk)
//   DI          MOSI
//   DO          MISO, 0 whenever no data byte is being shifted out
//   busy        synced chip select is active
//   cmd_err     one-clk pulse when an opcode is rejected
//   fsm_state   current FSM state for observation
module spi_flash_rom_sync
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD      = READ_OP,
    parameter logic [7:0] FAST_READ_CMD = FAST_READ_OP,
    parameter int         FAST_READ_EN  = 1,
    parameter int         DUMMY_CYCLES  = 8,
    parameter int         ADDR_BYTES    = 3,
    parameter int         MEM_AW        = 20,
    parameter string      MEM_FILE      = "mem.mif"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic       DI,
    output logic       DO,
    output logic       busy,
    output logic       cmd_err,
    output logic [2:0] fsm_state
);

    localparam logic [BIT_CNT_W-1:0] ADDR_LAST  = BIT_CNT_W'(8 * ADDR_BYTES - 1);
    localparam logic [BIT_CNT_W-1:0] DUMMY_LAST =
        BIT_CNT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

    logic cs_n_s, di_s, sclk_rise, sclk_fall;

    spi_pin_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .DI        (DI),
        .cs_n_s    (cs_n_s),
        .di_s      (di_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    logic [7:0] mem [2**MEM_AW];

    state_t                 state, next_state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [6:0]             cmd_sr;
    // Only the low MEM_AW address bits matter; older bits fall off the top.
    logic [MEM_AW-1:0]      addr_sr;
    logic [MEM_AW-1:0]      mem_addr;
    logic [7:0]             rd_data;
    logic [7:0]             shift_reg;
    logic                   is_fast;
    logic                   ld_req, ld_go;
    logic [7:0]             opcode;
    logic                   cmd_ok;
    logic                   go_dummy;

    // Registered ROM read: rd_data follows mem_addr one clk later.
    always_ff @(posedge clk) begin
        rd_data <= mem[mem_addr];
    end

    always_comb begin
        opcode     = {cmd_sr, di_s};
        cmd_ok     = (opcode == READ_CMD) ||
                     ((FAST_READ_EN != 0) && (opcode == FAST_READ_CMD));
        go_dummy   = is_fast && (DUMMY_CYCLES > 0);
        next_state = state;
        if (cs_n_s) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   next_state = ST_CMD;
                ST_CMD:    if (sclk_rise && bit_cnt == 6'd7)
                               next_state = cmd_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR:   if (sclk_rise && bit_cnt == ADDR_LAST)
                               next_state = go_dummy ? ST_DUMMY : ST_DATA;
                ST_DUMMY:  if (sclk_rise && bit_cnt == DUMMY_LAST)
                               next_state = ST_DATA;
                ST_DATA:   next_state = ST_DATA;
                ST_IGNORE: next_state = ST_IGNORE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            addr_sr   <= '0;
            mem_addr  <= '0;
            shift_reg <= '0;
            is_fast   <= 1'b0;
            ld_req    <= 1'b0;
            ld_go     <= 1'b0;
            DO        <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state   <= next_state;
            busy    <= ~cs_n_s;
            cmd_err <= 1'b0;
            // Two-stage load: mem_addr -> rd_data -> shift_reg.
            ld_req  <= 1'b0;
            ld_go   <= ld_req;
            if (cs_n_s) begin
                bit_cnt <= '0;
                is_fast <= 1'b0;
                ld_go   <= 1'b0;
                DO      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: bit_cnt <= '0;
                    ST_CMD: if (sclk_rise) begin
                        cmd_sr <= {cmd_sr[5:0], di_s};
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            is_fast <= (FAST_READ_EN != 0) && (opcode == FAST_READ_CMD);
                            cmd_err <= ~cmd_ok;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_ADDR: if (sclk_rise) begin
                        addr_sr <= {addr_sr[MEM_AW-2:0], di_s};
                        if (bit_cnt == ADDR_LAST) begin
                            bit_cnt  <= '0;
                            mem_addr <= {addr_sr[MEM_AW-2:0], di_s};
                            ld_req   <= ~go_dummy;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_DUMMY: if (sclk_rise) begin
                        if (bit_cnt == DUMMY_LAST) begin
                            bit_cnt <= '0;
                            ld_req  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (sclk_fall) begin
                            DO        <= shift_reg[7];
                            shift_reg <= {shift_reg[6:0], 1'b0};
                        end
                        // The master has sampled the 8th bit: fetch the next byte.
                        if (sclk_rise) begin
                            if (bit_cnt == 6'd7) begin
                                bit_cnt <= '0;
                                ld_req  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        // A load never coincides with sclk_fall given clk >= 8x sclk.
                        if (ld_go) begin
                            shift_reg <= rd_data;
                            mem_addr  <= mem_addr + 1'b1;
                        end
                    end
                    ST_IGNORE: DO <= 1'b0;
                    default:   DO <= 1'b0;
                endcase
            end
        end
    end

    assign fsm_state = state;

endmodule
